// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and constants for the pipeline controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } pctl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_load_use_det.sv
// ============================================================================
// load_use_det : flags an ID-stage read of the register an EX-stage load writes
// Revision     : 1.0
// ============================================================================
`default_nettype none

module load_use_det #(
  parameter int RID_W = 5
) (
  input  logic [RID_W-1:0] i_id_rs1,
  input  logic [RID_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_is_load,
  input  logic [RID_W-1:0] i_ex_rd,
  output logic             o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign o_hazard  = i_ex_is_load && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : IF/ID/EX hold, flush and redirect control with MDU watchdog
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int RID_W       = 5,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RID_W-1:0]  id_rs1,
  input  logic [RID_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [RID_W-1:0]  ex_rd,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_hold,
  output logic              id_ex_flush,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              mdu_err,
  output logic [31:0]       stall_cnt
);

  localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

  pctl_state_t      r_state;
  pctl_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_mdu_err;
  logic [31:0]      r_stall_cnt;
  logic             w_hazard;
  logic             w_pc_hold;
  logic             w_if_id_hold;
  logic             w_if_id_flush;
  logic             w_id_ex_hold;
  logic             w_id_ex_flush;
  logic             w_jump_en;

  load_use_det #(
    .RID_W (RID_W)
  ) u_load_use_det (
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .o_hazard     (w_hazard)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_mdu_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN && mdu_start && !mdu_done) begin
        r_cnt <= '0;
      end else if (r_state == ST_MDU_WAIT && !mdu_done) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_state_nxt == ST_ERR) begin
        r_mdu_err <= 1'b1;
      end
      if (w_pc_hold && r_state != ST_INIT && r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:     w_state_nxt = ST_RUN;
      ST_RUN:      if (mdu_start && !mdu_done) w_state_nxt = ST_MDU_WAIT;
      ST_MDU_WAIT: begin
        if (mdu_done) begin
          w_state_nxt = ST_RUN;
        end else if (w_cnt_inc == CNT_W'(MDU_TIMEOUT - 1)) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_ERR:      w_state_nxt = ST_ERR;
      default:     w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_pc_hold     = 1'b0;
    w_if_id_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_id_ex_flush = 1'b0;
    w_jump_en     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_pc_hold     = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end
      ST_RUN: begin
        // An MDU issue outranks a jump in the same cycle; a same-cycle done needs no stall
        if (mdu_start) begin
          if (!mdu_done) begin
            w_pc_hold    = 1'b1;
            w_if_id_hold = 1'b1;
            w_id_ex_hold = 1'b1;
          end
        end else if (jump_req) begin
          w_jump_en     = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_hazard) begin
          w_pc_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (!mdu_done) begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
        end
      end
      default: begin
        w_pc_hold    = 1'b1;
        w_if_id_hold = 1'b1;
        w_id_ex_hold = 1'b1;
      end
    endcase
  end

  assign pc_hold     = w_pc_hold;
  assign if_id_flush = w_if_id_flush;
  assign id_ex_flush = w_id_ex_flush;
  assign if_id_hold  = w_if_id_hold && !w_if_id_flush;
  assign id_ex_hold  = w_id_ex_hold && !w_id_ex_flush;
  assign jump_en     = w_jump_en;
  assign jump_addr_o = w_jump_en ? jump_addr : '0;
  assign mdu_err     = r_mdu_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire
